// File: rtl/global_buffer_pkg.sv
// Shared types and sizing for the global-buffer tile: header/packet layouts and the load-DMA state set.
package global_buffer_pkg;

  localparam int QUEUE_DEPTH         = 4;
  localparam int GLB_ADDR_WIDTH      = 22;
  localparam int BANK_DATA_WIDTH     = 64;
  localparam int CGRA_DATA_WIDTH     = 16;
  localparam int MAX_NUM_WORDS_WIDTH = 16;
  localparam int DUTY_WIDTH          = 8;

  typedef struct packed {
    logic                           valid;
    logic                           repeat_on;
    logic                           inactive_on;
    logic [GLB_ADDR_WIDTH-1:0]      start_addr;
    logic [MAX_NUM_WORDS_WIDTH-1:0] num_words;
    logic [DUTY_WIDTH-1:0]          active_words_per_cycle;
    logic [DUTY_WIDTH-1:0]          inactive_words_per_cycle;
  } dma_ld_header_t;

  typedef struct packed {
    logic                      rd_en;
    logic [GLB_ADDR_WIDTH-1:0] rd_addr;
  } rdrq_packet_t;

  typedef struct packed {
    logic                       rd_data_valid;
    logic [BANK_DATA_WIDTH-1:0] rd_data;
  } rdrs_packet_t;

  typedef enum logic [2:0] {
    IDLE, LOAD, REQ, WAIT, STREAM, GAP, DONE
  } ld_dma_state_e;

  function automatic logic [CGRA_DATA_WIDTH-1:0] lane_sel(
    input logic [BANK_DATA_WIDTH-1:0] word,
    input logic [1:0]                 idx
  );
    return word[CGRA_DATA_WIDTH*idx +: CGRA_DATA_WIDTH];
  endfunction

endpackage

// File: rtl/glb_ld_hdr_fifo.sv
// Circular header FIFO; pushes that cannot be accepted are dropped and flagged for one cycle on 'drop'.
module glb_ld_hdr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign rd_data = mem_q[rd_ptr_q];
  assign do_rd   = rd_en && !empty;
  // A pop frees a slot in the same cycle, so a full queue still takes a simultaneous push.
  assign do_wr   = wr_en && (!full || do_rd);
  assign drop    = wr_en && !do_wr;

  always_comb begin
    wr_ptr_d = do_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_rd ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_rd) begin
      count_d = count_q + CW'(1);
    end else if (!do_wr && do_rd) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_wr) begin
        mem_q[wr_ptr_q] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/glb_tile_ld_dma.sv
// Load-side DMA of a GLB tile: pops headers, reads bank words one at a time and streams 16-bit lanes to the CGRA.
module glb_tile_ld_dma
  import global_buffer_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       hdr_wr_en,
  input  dma_ld_header_t             hdr_wr_data,
  input  logic                       start_pulse,
  output rdrq_packet_t               rdrq,
  input  rdrs_packet_t               rdrs,
  output logic [CGRA_DATA_WIDTH-1:0] data_g2f,
  output logic                       data_valid_g2f,
  output logic                       done_pulse,
  output logic                       q_full,
  output logic                       q_empty,
  output logic                       hdr_overflow
);

  ld_dma_state_e                  state_q, state_d;
  logic                           armed_q, armed_d;
  dma_ld_header_t                 hdr_q, hdr_d;
  logic [GLB_ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [1:0]                     off_q, off_d;
  logic [MAX_NUM_WORDS_WIDTH-1:0] remaining_q, remaining_d;
  logic [BANK_DATA_WIDTH-1:0]     buf_q, buf_d;
  logic [DUTY_WIDTH-1:0]          word_cnt_q, word_cnt_d;
  logic [DUTY_WIDTH-1:0]          gap_cnt_q, gap_cnt_d;
  logic                           need_req_q, need_req_d;
  logic                           overflow_q, overflow_d;
  rdrq_packet_t                   rdrq_q, rdrq_d;
  logic [CGRA_DATA_WIDTH-1:0]     data_q, data_d;
  logic                           valid_q, valid_d;
  logic                           done_q, done_d;

  logic                           repush, ext_push;
  logic                           fifo_wr_en, fifo_rd_en, fifo_full, fifo_empty, fifo_drop;
  dma_ld_header_t                 fifo_wr_data, fifo_head;
  logic [DUTY_WIDTH-1:0]          active_lim;
  logic                           gap_due, lane_wrap;

  assign ext_push     = hdr_wr_en && hdr_wr_data.valid;
  assign repush       = (state_q == DONE) && hdr_q.repeat_on;
  assign fifo_wr_en   = repush || ext_push;
  assign fifo_wr_data = repush ? hdr_q : hdr_wr_data;
  assign fifo_rd_en   = (state_q == LOAD);

  glb_ld_hdr_fifo #(
    .WIDTH($bits(dma_ld_header_t)),
    .DEPTH(QUEUE_DEPTH)
  ) u_hdr_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (fifo_wr_en),
    .wr_data (fifo_wr_data),
    .rd_en   (fifo_rd_en),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .drop    (fifo_drop)
  );

  // The word counter counts valid words since the last gap; bank refills do not restart it.
  assign active_lim = (hdr_q.active_words_per_cycle == '0) ? DUTY_WIDTH'(1)
                                                           : hdr_q.active_words_per_cycle;
  assign gap_due    = hdr_q.inactive_on && (hdr_q.inactive_words_per_cycle != '0) &&
                      ((word_cnt_q + DUTY_WIDTH'(1)) >= active_lim);
  assign lane_wrap  = (off_q == 2'd3);

  always_comb begin
    state_d     = state_q;
    armed_d     = armed_q;
    hdr_d       = hdr_q;
    addr_d      = addr_q;
    off_d       = off_q;
    remaining_d = remaining_q;
    buf_d       = buf_q;
    word_cnt_d  = word_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    need_req_d  = need_req_q;
    overflow_d  = overflow_q | fifo_drop | (repush && ext_push);

    unique case (state_q)
      IDLE: begin
        armed_d = armed_q | start_pulse;
        if ((armed_q || start_pulse) && !fifo_empty) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        hdr_d       = fifo_head;
        addr_d      = {fifo_head.start_addr[GLB_ADDR_WIDTH-1:3], 3'b000};
        off_d       = fifo_head.start_addr[2:1];
        remaining_d = fifo_head.num_words;
        word_cnt_d  = '0;
        need_req_d  = 1'b0;
        state_d     = (fifo_head.num_words == '0) ? DONE : REQ;
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (rdrs.rd_data_valid) begin
          buf_d   = rdrs.rd_data;
          state_d = STREAM;
        end
      end
      STREAM: begin
        off_d       = off_q + 2'd1;
        remaining_d = remaining_q - MAX_NUM_WORDS_WIDTH'(1);
        word_cnt_d  = word_cnt_q + DUTY_WIDTH'(1);
        if (lane_wrap) begin
          addr_d = addr_q + GLB_ADDR_WIDTH'(8);
        end
        if (remaining_q == MAX_NUM_WORDS_WIDTH'(1)) begin
          state_d = DONE;
        end else if (gap_due) begin
          state_d    = GAP;
          gap_cnt_d  = hdr_q.inactive_words_per_cycle - DUTY_WIDTH'(1);
          word_cnt_d = '0;
          need_req_d = lane_wrap;
        end else if (lane_wrap) begin
          state_d = REQ;
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = need_req_q ? REQ : STREAM;
        end else begin
          gap_cnt_d = gap_cnt_q - DUTY_WIDTH'(1);
        end
      end
      DONE: begin
        if (!fifo_empty || repush) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
          armed_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered as a decode of the state being entered.
    rdrq_d = '0;
    if (state_d == REQ) begin
      rdrq_d.rd_en   = 1'b1;
      rdrq_d.rd_addr = addr_d;
    end
    valid_d = (state_d == STREAM);
    data_d  = valid_d ? lane_sel(buf_d, off_d) : '0;
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      armed_q     <= 1'b0;
      hdr_q       <= '0;
      addr_q      <= '0;
      off_q       <= '0;
      remaining_q <= '0;
      buf_q       <= '0;
      word_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      need_req_q  <= 1'b0;
      overflow_q  <= 1'b0;
      rdrq_q      <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      hdr_q       <= hdr_d;
      addr_q      <= addr_d;
      off_q       <= off_d;
      remaining_q <= remaining_d;
      buf_q       <= buf_d;
      word_cnt_q  <= word_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      need_req_q  <= need_req_d;
      overflow_q  <= overflow_d;
      rdrq_q      <= rdrq_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  assign rdrq           = rdrq_q;
  assign data_g2f       = data_q;
  assign data_valid_g2f = valid_q;
  assign done_pulse     = done_q;
  assign q_full         = fifo_full;
  assign q_empty        = fifo_empty;
  assign hdr_overflow   = overflow_q;

endmodule

// File: tb/tb_glb_tile_ld_dma.sv
// Bench for glb_tile_ld_dma: directed and random headers against a lane/timing reference model.
module tb_glb_tile_ld_dma;
  import global_buffer_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset_n;
  logic                       hdr_wr_en;
  dma_ld_header_t             hdr_wr_data;
  logic                       start_pulse;
  rdrq_packet_t               rdrq;
  rdrs_packet_t               rdrs;
  logic [CGRA_DATA_WIDTH-1:0] data_g2f;
  logic                       data_valid_g2f;
  logic                       done_pulse;
  logic                       q_full;
  logic                       q_empty;
  logic                       hdr_overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int respLat = 2;
  int respCnt = 0;
  logic [GLB_ADDR_WIDTH-1:0] respAddr;

  logic [63:0] bankMem [int unsigned];
  logic [15:0] outVal [$];
  int          outCyc [$];
  logic [21:0] reqAddr [$];
  int          reqCyc [$];
  int          doneCyc [$];
  logic [15:0] expVal [$];
  int          expCyc [$];
  logic [21:0] expRAddr [$];
  int          expRCyc [$];
  int          expDone;

  glb_tile_ld_dma dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .hdr_wr_en      (hdr_wr_en),
    .hdr_wr_data    (hdr_wr_data),
    .start_pulse    (start_pulse),
    .rdrq           (rdrq),
    .rdrs           (rdrs),
    .data_g2f       (data_g2f),
    .data_valid_g2f (data_valid_g2f),
    .done_pulse     (done_pulse),
    .q_full         (q_full),
    .q_empty        (q_empty),
    .hdr_overflow   (hdr_overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] getWord(input int unsigned a);
    if (!bankMem.exists(a)) bankMem[a] = {$urandom, $urandom};
    return bankMem[a];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Bank responder: answers each rd_en after respLat cycles, driven mid-cycle.
  always @(negedge clk) begin
    rdrs.rd_data_valid = 1'b0;
    rdrs.rd_data       = '0;
    if (!reset_n) begin
      respCnt = 0;
    end else begin
      if (respCnt > 0) begin
        respCnt--;
        if (respCnt == 0) begin
          rdrs.rd_data_valid = 1'b1;
          rdrs.rd_data       = getWord(respAddr);
        end
      end
      if (rdrq.rd_en) begin
        if (respCnt != 0) checkOutput("one_outstanding", 1, 0);
        respCnt  = respLat;
        respAddr = rdrq.rd_addr;
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (data_valid_g2f) begin outVal.push_back(data_g2f); outCyc.push_back(cyc); end
      if (done_pulse) doneCyc.push_back(cyc);
      if (rdrq.rd_en) begin reqAddr.push_back(rdrq.rd_addr); reqCyc.push_back(cyc); end
    end
  end

  function automatic dma_ld_header_t mkHdr(input int sa, input int n, input bit inOn,
                                           input int act, input int inact, input bit rep);
    dma_ld_header_t h;
    h.valid                    = 1'b1;
    h.repeat_on                = rep;
    h.inactive_on              = inOn;
    h.start_addr               = GLB_ADDR_WIDTH'(sa);
    h.num_words                = MAX_NUM_WORDS_WIDTH'(n);
    h.active_words_per_cycle   = DUTY_WIDTH'(act);
    h.inactive_words_per_cycle = DUTY_WIDTH'(inact);
    return h;
  endfunction

  // Word k lives at half-word index start/2+k; timing follows the state latencies.
  task automatic buildModel(input dma_ld_header_t h, input int s, input int lat);
    int unsigned hw, ba;
    int n, a, gi, g, lane, t;
    logic [63:0] w;
    expVal.delete(); expCyc.delete(); expRAddr.delete(); expRCyc.delete();
    hw = h.start_addr >> 1;
    n  = h.num_words;
    a  = (h.active_words_per_cycle == 0) ? 1 : int'(h.active_words_per_cycle);
    gi = h.inactive_on ? int'(h.inactive_words_per_cycle) : 0;
    t  = 0;
    if (n == 0) begin
      expDone = s + 2;
    end else begin
      for (int k = 0; k < n; k++) begin
        lane = int'((hw + k) % 4);
        ba   = (((hw + k) >> 2) << 3) & ((1 << GLB_ADDR_WIDTH) - 1);
        if (k == 0) begin
          expRAddr.push_back(22'(ba)); expRCyc.push_back(s + 2);
          t = s + 2 + lat + 1;
        end else begin
          g = (gi > 0 && (k % a) == 0) ? gi : 0;
          if (lane == 0) begin
            expRAddr.push_back(22'(ba)); expRCyc.push_back(t + 1 + g);
            t = t + 1 + g + lat + 1;
          end else begin
            t = t + 1 + g;
          end
        end
        w = getWord(ba);
        expVal.push_back(w[16*lane +: 16]);
        expCyc.push_back(t);
      end
      expDone = t + 1;
    end
  endtask

  task automatic clearLogs();
    outVal.delete(); outCyc.delete(); reqAddr.delete(); reqCyc.delete(); doneCyc.delete();
  endtask

  task automatic compareRun(input string id);
    checkOutput({id, "_nwords"}, outVal.size(), expVal.size());
    for (int k = 0; k < expVal.size() && k < outVal.size(); k++) begin
      checkOutput($sformatf("%s_w%0d_data", id, k), outVal[k], expVal[k]);
      checkOutput($sformatf("%s_w%0d_cyc", id, k), outCyc[k], expCyc[k]);
    end
    checkOutput({id, "_nreads"}, reqAddr.size(), expRAddr.size());
    for (int k = 0; k < expRAddr.size() && k < reqAddr.size(); k++) begin
      checkOutput($sformatf("%s_r%0d_addr", id, k), reqAddr[k], expRAddr[k]);
      checkOutput($sformatf("%s_r%0d_cyc", id, k), reqCyc[k], expRCyc[k]);
    end
    checkOutput({id, "_ndone"}, doneCyc.size(), 1);
    if (doneCyc.size() > 0) checkOutput({id, "_done_cyc"}, doneCyc[0], expDone);
  endtask

  task automatic waitDone(input int want, input int budget);
    for (int i = 0; i < budget && doneCyc.size() < want; i++) begin
      @(negedge clk); #1;
    end
  endtask

  // Pushes one header, pulses start, runs to completion and compares with the model.
  task automatic applyStimulus(input string id, input dma_ld_header_t h, input int lat);
    int s;
    respLat = lat;
    clearLogs();
    @(negedge clk); hdr_wr_en = 1'b1; hdr_wr_data = h;
    @(negedge clk); hdr_wr_en = 1'b0; start_pulse = 1'b1; s = cyc;
    @(negedge clk); start_pulse = 1'b0;
    waitDone(1, 3000);
    repeat (4) @(negedge clk);
    #1;
    buildModel(h, s, lat);
    compareRun(id);
  endtask

  task automatic pulseReset();
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
  endtask

  initial begin
    dma_ld_header_t h;
    int s;
    #1000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    dma_ld_header_t h;
    int s, found;
    reset_n = 1'b0; hdr_wr_en = 1'b0; hdr_wr_data = '0; start_pulse = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_valid", data_valid_g2f, 0);
    checkOutput("rst_rden", rdrq.rd_en, 0);
    checkOutput("rst_done", done_pulse, 0);
    checkOutput("rst_empty", q_empty, 1);
    checkOutput("rst_full", q_full, 0);
    checkOutput("rst_ovf", hdr_overflow, 0);
    reset_n = 1'b1;

    bankMem[0] = 64'h0004_0003_0002_0001;
    applyStimulus("t1", mkHdr(0, 4, 0, 0, 0, 0), 2);
    for (int k = 0; k < 4 && k < outVal.size(); k++)
      checkOutput($sformatf("t1_const%0d", k), outVal[k], 64'(k + 1));

    applyStimulus("t2", mkHdr('h6, 3, 0, 0, 0, 0), 2);
    applyStimulus("t3", mkHdr(0, 8, 1, 2, 3, 0), 2);
    applyStimulus("t6", mkHdr('h3F_FFF8, 8, 0, 0, 0, 0), 2);
    if (reqAddr.size() > 1) checkOutput("t6_wrap_addr", reqAddr[1], 0);

    // Repeat header replays until reset; reset mid-stream clears outputs at once.
    respLat = 2;
    clearLogs();
    h = mkHdr('h40, 4, 0, 0, 0, 1);
    @(negedge clk); hdr_wr_en = 1'b1; hdr_wr_data = h;
    @(negedge clk); hdr_wr_en = 1'b0; start_pulse = 1'b1; s = cyc;
    @(negedge clk); start_pulse = 1'b0;
    waitDone(3, 500);
    buildModel(mkHdr('h40, 4, 0, 0, 0, 0), s, 2);
    checkOutput("t4_passes", doneCyc.size() >= 3, 1);
    if (doneCyc.size() >= 2) checkOutput("t4_period", doneCyc[1] - doneCyc[0], 2 + 4 + 3);
    for (int k = 0; k < 12 && k < outVal.size(); k++)
      checkOutput($sformatf("t4_w%0d", k), outVal[k], expVal[k % 4]);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk); #1;
      found = data_valid_g2f;
    end
    checkOutput("t4_midstream", found, 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("t4_rst_valid", data_valid_g2f, 0);
    checkOutput("t4_rst_data", data_g2f, 0);
    checkOutput("t4_rst_rdrq", rdrq, 0);
    checkOutput("t4_rst_done", done_pulse, 0);
    checkOutput("t4_rst_empty", q_empty, 1);
    @(negedge clk); reset_n = 1'b1;
    clearLogs();
    repeat (12) @(negedge clk);
    #1;
    checkOutput("t4_quiet", outVal.size() + doneCyc.size() + reqAddr.size(), 0);

    // Queue fill without start: the fifth push overflows.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); hdr_wr_en = 1'b1; hdr_wr_data = mkHdr(8 * i, 1, 0, 0, 0, 0);
      if (i == 4) begin
        #1;
        checkOutput("t5_ovf_before", hdr_overflow, 0);
      end
    end
    @(negedge clk); hdr_wr_en = 1'b0;
    #1;
    checkOutput("t5_full", q_full, 1);
    checkOutput("t5_ovf", hdr_overflow, 1);
    checkOutput("t5_empty", q_empty, 0);
    pulseReset();
    #1;
    checkOutput("t5_ovf_cleared", hdr_overflow, 0);
    h = mkHdr(0, 5, 0, 0, 0, 0);
    h.valid = 1'b0;
    @(negedge clk); hdr_wr_en = 1'b1; hdr_wr_data = h;
    @(negedge clk); hdr_wr_en = 1'b0;
    #1;
    checkOutput("t5_invalid_dropped", q_empty, 1);
    applyStimulus("t5z", mkHdr('h100, 0, 0, 0, 0, 0), 2);

    for (int r = 0; r < 8; r++) begin
      applyStimulus($sformatf("rnd%0d", r),
                    mkHdr(int'($urandom_range(0, (1 << GLB_ADDR_WIDTH) - 1)),
                          int'($urandom_range(1, 20)), 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0),
                    int'($urandom_range(1, 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
